mdu32: RTL and testbench

- Iterative multiply/divide unit that sits beside the 32-bit add/subtract datapath in the EX stage.
- Consumes the same register-file operands (a, b) and produces a 64-bit result into hi/lo.
- Uses a start/busy/done handshake so the pipeline can stall while it runs.
- One operation takes 34 cycles: radix-2 shift-add for multiply, restoring shift-subtract for divide, with sign fix-up for signed ops.

---
 rtl/mdu32_pkg.sv | 28 ++
 rtl/mdu32_step.sv | 30 +++
 rtl/mdu32.sv | 189 ++++++++++++++++++
 tb/tb_mdu32.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mdu32_pkg.sv
// mdu32_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), also used by
//     the EX-stage decoder
//   - FSM state type for the unit's IDLE/CALC/FIX sequence
//   - small op-decode helpers
package mdu32_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    // Bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic mdu_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu32_step.sv
// mdu32_step: combinational (WIDTH+1)-bit add/subtract with carry/borrow out.
// Used for the multiply partial-product add and the divide trial subtract.
//   i_x    : first operand, WIDTH+1 bits
//   i_y    : second operand, WIDTH+1 bits
//   i_sub  : 0 = i_x + i_y, 1 = i_x - i_y
//   o_res  : low WIDTH+1 bits of the result
//   o_cout : carry out (add) or borrow out (subtract, 1 = result negative)
module mdu32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_x,
    input  logic [WIDTH:0] i_y,
    input  logic           i_sub,
    output logic [WIDTH:0] o_res,
    output logic           o_cout
);

    logic [WIDTH+1:0] w_ext;

    always_comb begin
        if (i_sub) begin
            w_ext = {1'b0, i_x} - {1'b0, i_y};
        end else begin
            w_ext = {1'b0, i_x} + {1'b0, i_y};
        end
        o_res  = w_ext[WIDTH:0];
        o_cout = w_ext[WIDTH+1];
    end

endmodule

// File: rtl/mdu32.sv
// mdu32: iterative multiply/divide unit for the EX stage.
// One operation takes 34 cycles: a start edge, 32 radix-2 iterations
// (shift-add multiply or restoring shift-subtract divide) and a sign
// fix-up edge that writes hi/lo/dz and pulses done.
//   clk   : clock, rising edge
//   clrn  : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   op    : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b  : multiplicand/dividend, multiplier/divisor
//   busy  : operation in progress
//   done  : one-cycle pulse when hi/lo/dz are updated
//   hi/lo : product[63:32]/[31:0] or remainder/quotient
//   dz    : divide-by-zero flag of the last completed operation
module mdu32
    import mdu32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t         r_state;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;    // upper accumulator / partial remainder
    logic [WIDTH-1:0]   r_q;      // multiplier (shifting out) / quotient
    logic [WIDTH-1:0]   r_mcand;  // multiplicand / divisor magnitude
    logic               r_sa;
    logic               r_sb;
    logic               r_bz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    logic               w_div;
    logic               w_signed;
    logic               w_in_signed;
    logic [WIDTH:0]     w_step_x;
    logic [WIDTH:0]     w_step_y;
    logic [WIDTH:0]     w_step_res;
    logic               w_step_cout;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_nxt_acc;
    logic [WIDTH-1:0]   w_nxt_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    // Magnitude of a two's-complement value; the most negative value maps
    // to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x,
                                               input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    assign w_div       = mdu_is_div(r_op);
    assign w_signed    = mdu_is_signed(r_op);
    assign w_in_signed = mdu_is_signed(op);
    assign w_abs_a     = f_abs(a, w_in_signed);
    assign w_abs_b     = f_abs(b, w_in_signed);

    // Divide shifts the next dividend bit into the remainder before the
    // trial subtract; multiply adds into the zero-extended accumulator.
    assign w_step_x = w_div ? {r_acc, r_q[WIDTH-1]} : {1'b0, r_acc};
    assign w_step_y = {1'b0, r_mcand};

    mdu32_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_x    (w_step_x),
        .i_y    (w_step_y),
        .i_sub  (w_div),
        .o_res  (w_step_res),
        .o_cout (w_step_cout)
    );

    always_comb begin
        w_mul_sum = r_q[0] ? w_step_res : {1'b0, r_acc};
        if (w_div) begin
            // A borrow means the trial went negative: keep the shifted value.
            w_nxt_acc = w_step_cout ? w_step_x[WIDTH-1:0] : w_step_res[WIDTH-1:0];
            w_nxt_q   = {r_q[WIDTH-2:0], ~w_step_cout};
        end else begin
            // Shift {carry, acc, multiplier} right by one.
            w_nxt_acc = w_mul_sum[WIDTH:1];
            w_nxt_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = {r_acc, r_q};
        w_fix_hi = r_acc;
        w_fix_lo = r_q;
        if (w_div) begin
            if (w_signed && (r_sa ^ r_sb)) begin
                w_fix_lo = -r_q;
            end
            // Remainder follows the dividend sign; with a zero divisor the
            // remainder equals |a|, so this also restores the original a.
            if (w_signed && r_sa) begin
                w_fix_hi = -r_acc;
            end
            if (r_bz) begin
                w_fix_lo = '1;
            end
        end else if (w_signed && (r_sa ^ r_sb)) begin
            {w_fix_hi, w_fix_lo} = -w_prod;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_mcand <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= b[WIDTH-1];
                        r_bz    <= (b == '0);
                        r_mcand <= mdu_is_div(op) ? w_abs_b : w_abs_a;
                        r_q     <= mdu_is_div(op) ? w_abs_a : w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_nxt_acc;
                    r_q   <= w_nxt_q;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == '1) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_dz    <= w_div && r_bz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: directed-vector bench for mdu32.
// Each operation is started on a start edge E0; done is expected to be
// observed right after edge E33, with busy high from E0 through E32.
module tb_mdu32;
    import mdu32_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one operation and check latency, busy window, hold behaviour and
    // the final hi/lo/dz. With inject set, a second start with another op
    // is pulsed during iteration 10 and must be ignored.
    task automatic run(input string name, input logic [1:0] o,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input bit inject);
        int          lat;
        int          bcnt;
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 16) begin
                chk({name, "_hold_hi"}, hi, hi0);
                chk({name, "_hold_lo"}, lo, lo0);
            end
            if (inject && n == 10) begin
                start = 1'b1;
                op    = MDU_MULTU;
                a     = 32'd2;
                b     = 32'd3;
            end
            if (inject && n == 11) begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
            end else if (busy) begin
                bcnt++;
            end
        end
        chk({name, "_latency"}, lat, 33);
        chk({name, "_busy_cycles"}, bcnt, 33);
        chk({name, "_busy_at_done"}, busy, 1'b0);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
        chk({name, "_dz"}, dz, edz);
    endtask

    initial begin
        logic seen_done;
        clrn  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_dz", dz, 1'b0);
        @(negedge clk);
        clrn = 1'b1;

        run("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 1'b0);
        run("mult_min", MDU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run("mult_m1", MDU_MULT, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 1'b0);
        run("divu_ign", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        run("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("div_dz", MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
        run("multu_clr", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);
        run("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
        run("div_dz_neg", MDU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);

        // Abort a DIVU partway through with the asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_dz", dz, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        chk("abort_no_done", seen_done, 1'b0);
        chk("abort_idle_busy", busy, 1'b0);

        run("divu_small", MDU_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
